// File: rtl/seq_det_pkg.sv
// Shared constants for the serial-pattern detector: FSM encodings,
// the power-up pattern and a helper sizing the fill counter.
package seq_det_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [4:0] RST_PAT_DEFAULT = 5'b10001;

  // Fill counts 0..pat_w inclusive, so it needs room for pat_w+1 values.
  function automatic int fill_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_window_match.sv
// Shift window, fill counter and pattern compare. The hit output is
// combinational and reflects the window as it will be after the current beat.
module seq_window_match
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             beat,
  input  logic             bit_in,
  input  logic             overlap,
  input  logic [PAT_W-1:0] pattern,
  output logic             hit
);

  localparam int FW = fill_w(PAT_W);
  localparam logic [FW-1:0] FILL_FULL = FW'(PAT_W);

  logic [PAT_W-1:0] window_reg;
  logic [PAT_W-1:0] window_next;
  logic [FW-1:0]    fill_reg;
  logic [FW-1:0]    fill_next;

  // Post-beat window/fill and the hit decision taken on them.
  always_comb begin
    window_next = (window_reg << 1) | {{(PAT_W-1){1'b0}}, bit_in};
    fill_next   = (fill_reg == FILL_FULL) ? fill_reg : fill_reg + 1'b1;
    hit         = beat && (fill_next == FILL_FULL) && (window_next == pattern);
  end

  // Window/fill state; a non-overlapping hit restarts the fill so the
  // next hit must be built entirely from fresh bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      window_reg <= '0;
      fill_reg   <= '0;
    end else if (clear) begin
      window_reg <= '0;
      fill_reg   <= '0;
    end else if (beat) begin
      window_reg <= window_next;
      fill_reg   <= (hit && !overlap) ? '0 : fill_next;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller for the programmable serial-pattern detector: config
// registers, IDLE/ARMED/DONE sequencing, saturating hit counter and the
// registered match pulse.
module seq_detect_ctrl
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 5,
  parameter int               CNT_W   = 8,
  parameter int               OVERLAP = 0,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(RST_PAT_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             start,
  input  logic             abort,
  input  logic             bit_valid,
  output logic             bit_ready,
  input  logic             bit_in,
  output logic             match,
  output logic [CNT_W-1:0] hit_count,
  output logic             busy,
  output logic             done
);

  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic [PAT_W-1:0] pattern_reg;
  logic [CNT_W-1:0] target_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_inc;
  logic             match_reg;
  logic             beat;
  logic             clear;
  logic             hit;
  logic             cfg_take;
  logic             reach;

  // Status outputs are pure state decodes; match is the only registered pulse.
  assign cfg_ready = (state_reg == ST_IDLE);
  assign bit_ready = (state_reg == ST_ARMED);
  assign busy      = (state_reg == ST_ARMED);
  assign done      = (state_reg == ST_DONE);
  assign match     = match_reg;
  assign hit_count = count_reg;

  // Abort outranks everything: it kills the beat (so any hit is dropped),
  // the config write and the start.
  assign beat     = bit_valid && bit_ready && !abort;
  assign cfg_take = (state_reg == ST_IDLE) && cfg_valid && !abort;
  assign clear    = !abort && start &&
                    (((state_reg == ST_IDLE) && !cfg_valid) || (state_reg == ST_DONE));

  seq_window_match #(
    .PAT_W(PAT_W)
  ) u_window (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .beat   (beat),
    .bit_in (bit_in),
    .overlap(OVERLAP != 0),
    .pattern(pattern_reg),
    .hit    (hit)
  );

  // Saturating increment and target detection for the hit on this edge.
  always_comb begin
    count_inc = (&count_reg) ? count_reg : count_reg + 1'b1;
    reach     = hit && (target_reg != '0) && (count_inc == target_reg);
  end

  // Next-state selection for the run FSM.
  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:  if (!cfg_valid && start) state_next = ST_ARMED;
        ST_ARMED: if (reach) state_next = ST_DONE;
        ST_DONE:  if (start) state_next = ST_ARMED;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // State, configuration, hit counter and match pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      pattern_reg <= RST_PAT;
      target_reg  <= CNT_W'(1);
      count_reg   <= '0;
      match_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      match_reg <= hit;
      if (cfg_take) begin
        pattern_reg <= cfg_pattern;
        target_reg  <= cfg_target;
      end
      if (clear) begin
        count_reg <= '0;
      end else if (hit) begin
        count_reg <= count_inc;
      end
    end
  end

endmodule
